// File: rtl/mul_master.sv
// Bus master that runs one signed multiply on an external responder:
// clear, write two operands, read back the product, with per-phase ready timeout.
module mul_master #(
    parameter int SZin = 8,
    parameter int TMO  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SZin-1:0]     op_a,
    input  logic [SZin-1:0]     op_b,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2*SZin-2:0]   result,
    output logic                sel,
    output logic                wrt,
    output logic                nres,
    output logic                addr_b,
    output logic [SZin-1:0]     wdata,
    input  logic [2*SZin-2:0]   rdata,
    input  logic                ready
);

    localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_WR_A = 3'd2;
    localparam logic [2:0] S_WR_B = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [CW-1:0] TMO_C  = CW'(TMO);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] ZERO_C = CW'(0);

    logic [2:0]          state_r;
    logic [2:0]          state_nx_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_nx_s;
    logic                timeout_s;
    logic                in_phase_s;
    logic [SZin-1:0]     opa_r;
    logic [SZin-1:0]     opb_r;
    logic [2*SZin-2:0]   result_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                sel_r;
    logic                wrt_r;
    logic                nres_r;
    logic                addr_b_r;
    logic [SZin-1:0]     wdata_r;
    logic                sel_nx_s;
    logic                wrt_nx_s;
    logic                nres_nx_s;
    logic                addr_b_nx_s;
    logic [SZin-1:0]     wdata_nx_s;

    // Next-state logic; a phase tolerates TMO ready-low cycles, so ready
    // arriving while the counter already equals TMO still completes the phase.
    always_comb begin
        state_nx_s = state_r;
        timeout_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_CLR;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_CLR: begin
                state_nx_s = S_WR_A;
            end
            S_WR_A, S_WR_B, S_RD: begin
                if (ready) begin
                    if (state_r == S_WR_A) begin
                        state_nx_s = S_WR_B;
                    end else if (state_r == S_WR_B) begin
                        state_nx_s = S_RD;
                    end else begin
                        state_nx_s = S_FIN;
                    end
                end else if (cnt_r == TMO_C) begin
                    state_nx_s = S_IDLE;
                    timeout_s  = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_FIN: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Per-phase wait counter: restarts whenever the state changes.
    always_comb begin
        in_phase_s = (state_r == S_WR_A) || (state_r == S_WR_B) || (state_r == S_RD);
        cnt_nx_s   = cnt_r;
        if (state_nx_s != state_r) begin
            cnt_nx_s = ZERO_C;
        end else if (in_phase_s && !ready) begin
            cnt_nx_s = cnt_r + ONE_C;
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Bus outputs decoded from the next state so they can be registered.
    always_comb begin
        sel_nx_s    = 1'b0;
        wrt_nx_s    = 1'b0;
        nres_nx_s   = 1'b1;
        addr_b_nx_s = 1'b0;
        wdata_nx_s  = '0;
        case (state_nx_s)
            S_CLR: begin
                sel_nx_s  = 1'b1;
                nres_nx_s = 1'b0;
            end
            S_WR_A: begin
                sel_nx_s   = 1'b1;
                wrt_nx_s   = 1'b1;
                wdata_nx_s = opa_r;
            end
            S_WR_B: begin
                sel_nx_s    = 1'b1;
                wrt_nx_s    = 1'b1;
                addr_b_nx_s = 1'b1;
                wdata_nx_s  = opb_r;
            end
            S_RD: begin
                sel_nx_s = 1'b1;
            end
            default: begin
                sel_nx_s = 1'b0;
            end
        endcase
    end

    // State, counter, operand/result capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= ZERO_C;
            opa_r    <= '0;
            opb_r    <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            sel_r    <= 1'b0;
            wrt_r    <= 1'b0;
            nres_r   <= 1'b1;
            addr_b_r <= 1'b0;
            wdata_r  <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if ((state_r == S_IDLE) && start) begin
                opa_r <= op_a;
                opb_r <= op_b;
            end
            if ((state_r == S_RD) && ready) begin
                result_r <= rdata;
            end
            busy_r   <= (state_nx_s != S_IDLE);
            done_r   <= (state_nx_s == S_FIN);
            err_r    <= timeout_s;
            sel_r    <= sel_nx_s;
            wrt_r    <= wrt_nx_s;
            nres_r   <= nres_nx_s;
            addr_b_r <= addr_b_nx_s;
            wdata_r  <= wdata_nx_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;
    assign result = result_r;
    assign sel    = sel_r;
    assign wrt    = wrt_r;
    assign nres   = nres_r;
    assign addr_b = addr_b_r;
    assign wdata  = wdata_r;

endmodule

// File: tb/tb_mul_master.sv
// Directed and randomized bench for mul_master (SZin=5) with a behavioural
// responder that applies per-phase ready delays and returns the signed product.
module tb_mul_master;

    localparam int SZ  = 5;
    localparam int TMO = 6;

    logic           clk;
    logic           rst;
    logic           start;
    logic [SZ-1:0]  op_a;
    logic [SZ-1:0]  op_b;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*SZ-2:0] result;
    logic           sel;
    logic           wrt;
    logic           nres;
    logic           addr_b;
    logic [SZ-1:0]  wdata;
    logic [2*SZ-2:0] rdata;
    logic           ready;

    int errors = 0;
    int checks = 0;
    logic [2*SZ-2:0] last_result;

    mul_master #(.SZin(SZ), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .err(err), .result(result),
        .sel(sel), .wrt(wrt), .nres(nres), .addr_b(addr_b), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_wrt"}, wrt, 0);
        chk({tag, "_nres"}, nres, 1);
        chk({tag, "_addr_b"}, addr_b, 0);
        chk({tag, "_wdata"}, wdata, 0);
    endtask

    // One transaction: waits are ready-low cycles per phase (WR_A, WR_B, RD).
    task automatic run_txn(input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                           input int wa, input int wb, input int wr,
                           input bit hold, input bit mutate);
        int w[3];
        int pa, pb, prod, cyc, n, ph, last_ph, cip;
        bit exp_to, rdy;
        logic [2*SZ-2:0] exp_p;
        w[0] = wa; w[1] = wb; w[2] = wr;
        pa = $signed(a);
        pb = $signed(b);
        prod = pa * pb;
        exp_p = prod[2*SZ-2:0];
        cyc = 1;
        exp_to = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!exp_to) begin
                if (w[i] > TMO) begin
                    cyc += TMO + 1;
                    exp_to = 1'b1;
                end else begin
                    cyc += w[i] + 1;
                end
            end
        end

        @(negedge clk);
        op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        n = 1;
        if (!hold) start = 1'b0;
        chk("clr_outputs", {sel, nres, wrt}, 3'b100);
        last_ph = -1;
        cip = 0;
        while (n <= 60) begin
            if (done || err) break;
            ph = -1;
            if (sel && wrt && !addr_b) ph = 0;
            else if (sel && wrt && addr_b) ph = 1;
            else if (sel && !wrt && nres) ph = 2;
            if (ph != last_ph) cip = 0;
            last_ph = ph;
            rdy = (ph >= 0) && (cip >= w[ph]);
            ready = rdy;
            rdata = (ph == 2 && rdy) ? exp_p : (2*SZ-1)'($urandom);
            if (ph == 0 && rdy) chk("wdata_op_a", wdata, a);
            if (ph == 1 && rdy) chk("wdata_op_b", wdata, b);
            if (mutate) begin
                op_a = SZ'($urandom);
                op_b = SZ'($urandom);
            end
            cip++;
            @(negedge clk);
            n++;
        end
        ready = 1'b0;
        chk("end_cycle", n, cyc + 1);
        chk("done", done, !exp_to);
        chk("err", err, exp_to);
        chk("busy_at_end", busy, !exp_to);
        if (!exp_to) last_result = exp_p;
        chk("result", result, last_result);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("err_pulse", err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sel", sel, 0);
        chk("idle_wdata", wdata, 0);
        chk("result_hold", result, last_result);
    endtask

    initial begin
        int wa, wb, wr;
        rst = 1'b1; start = 1'b0; ready = 1'b0; rdata = '0;
        op_a = '0; op_b = '0;
        last_result = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        run_txn(5'b00010, 5'b00101, 0, 0, 0, 1'b0, 1'b0);
        run_txn(5'b11101, 5'b00101, 0, 0, 0, 1'b0, 1'b0);
        chk("neg_product", result, 9'b111110001);
        run_txn(5'b00111, 5'b11100, 0, 0, 3, 1'b0, 1'b0);
        run_txn(5'b01001, 5'b00011, 1, TMO, 2, 1'b0, 1'b0);
        run_txn(5'b00110, 5'b00110, 0, TMO + 1, 0, 1'b0, 1'b0);
        run_txn(5'b10000, 5'b10000, TMO + 1, 0, 0, 1'b0, 1'b0);
        run_txn(5'b01111, 5'b10001, 2, 1, TMO + 1, 1'b0, 1'b0);
        run_txn(5'b01011, 5'b11010, 1, 0, 2, 1'b1, 1'b1);

        // Start still held: IDLE lasted exactly one cycle, then a new run began.
        @(negedge clk);
        chk("restart_busy", busy, 1);
        start = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        chk("in_wr_a", {sel, wrt, addr_b, nres}, 4'b1101);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid_reset");
        last_result = '0;
        run_txn(5'b00011, 5'b11111, 0, 1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            wa = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, 3));
            wb = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, 3));
            wr = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            run_txn(SZ'($urandom), SZ'($urandom), wa, wb, wr, 1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_master.md
MUL_MASTER -- requirements
Module: mul_master

Interface
REQ-001 Parameter SZin, default 8: operand width in bits; the product is 2*SZin-1 bits, two's complement.
REQ-002 Parameter TMO, default 15: maximum number of cycles to wait for bus ready in any one phase.
REQ-003 clk  input  1: single clock; all logic updates on posedge clk.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 start  input  1: request one multiply; sampled only in IDLE.
REQ-006 op_a  input  SZin: operand 0, two's complement.
REQ-007 op_b  input  SZin: operand 1, two's complement.
REQ-008 busy  output  1: high in every state except IDLE.
REQ-009 done  output  1: one-cycle pulse when the result is valid.
REQ-010 err  output  1: one-cycle pulse when a phase times out.
REQ-011 result  output  2*SZin-1: product captured from the bus.
REQ-012 sel  output  1: bus select to the multiplier responder.
REQ-013 wrt  output  1: bus write strobe (1 = write operand, 0 = read product).
REQ-014 nres  output  1: active-low clear to the responder, driven low only in state CLR.
REQ-015 addr_b  output  1: operand address (0 = operand 0, 1 = operand 1).
REQ-016 wdata  output  SZin: operand data to the responder.
REQ-017 rdata  input  2*SZin-1: product from the responder.
REQ-018 ready  input  1: responder handshake; a phase completes on a posedge where ready==1.

Function
REQ-019 The FSM states SHALL be IDLE, CLR, WR_A, WR_B, RD, FIN.
REQ-020 IDLE with start==1 SHALL latch op_a and op_b into internal registers and go to CLR; start in any other state SHALL be ignored.
REQ-021 CLR SHALL last exactly one cycle with sel=1 and nres=0, then go to WR_A unconditionally.
REQ-022 WR_A SHALL drive sel=1, wrt=1, addr_b=0, wdata=latched op_a; on ready==1 it SHALL go to WR_B.
REQ-023 WR_B SHALL drive sel=1, wrt=1, addr_b=1, wdata=latched op_b; on ready==1 it SHALL go to RD.
REQ-024 RD SHALL drive sel=1, wrt=0, addr_b=0; on ready==1 it SHALL load result<=rdata and go to FIN.
REQ-025 FIN SHALL last one cycle with sel=0; done SHALL be 1 during FIN; the next state SHALL be IDLE.
REQ-026 Outside active phases, outputs SHALL idle at sel=0, wrt=0, nres=1, addr_b=0, wdata=0.
REQ-027 A per-phase cycle counter SHALL clear on entry to each of WR_A, WR_B and RD and increment each cycle ready==0.
REQ-028 If the counter reaches TMO with ready still 0, the FSM SHALL abort to IDLE, pulse err for one cycle and leave result unchanged.
REQ-029 ready==1 in the same cycle the counter reaches TMO SHALL count as success, not a timeout.
REQ-030 Minimum latency from start to done SHALL be 5 cycles (CLR, WR_A, WR_B, RD with ready already high, then FIN).
REQ-031 result SHALL hold its value until the next successful RD, and SHALL not be sign-adjusted by this block.
REQ-032 done and err SHALL never be high in the same cycle.
REQ-033 Latched operands SHALL be unaffected by changes on op_a or op_b while busy==1.

Reset
REQ-034 rst==1 at a posedge SHALL force IDLE and set busy=0, done=0, err=0, result=0, sel=0, wrt=0, nres=1, addr_b=0, wdata=0, and clear the counter and latched operands.
REQ-035 rst SHALL take priority over start, ready and timeout in the same cycle, including in the middle of any phase.

Verification
REQ-036 SZin=5, ready tied to 1, op_a=5'b00010, op_b=5'b00101, start pulse -> CLR, WR_A, WR_B, RD each for one cycle; done at cycle 5; result=9'd10.
REQ-037 SZin=5, op_a=-3, op_b=5 -> result=9'b111110001 (-15); done pulse one cycle wide.
REQ-038 ready held 0 in WR_B -> after TMO cycles: err=1 for one cycle, state IDLE, result keeps its previous value, busy=0.
REQ-039 ready delayed 3 cycles in RD, with rdata changing before ready rises -> result equals rdata sampled only at the ready==1 edge.
REQ-040 rst asserted during WR_A -> next cycle all outputs at reset values; a new start then completes normally.
REQ-041 start held high through an entire transaction -> exactly one transaction per IDLE visit; op_a changed mid-transaction does not alter wdata.
